// File: rtl/exc_ctrl.sv
// Exception controller: detects MEM-stage exceptions/interrupts/eret, drains
// outstanding data-memory traffic, commits one event to CP0 and redirects the PC.
module exc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        trap_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        adel_i,
  input  logic        ades_i,
  input  logic        eret_i,
  input  logic        mem_busy_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] newpc_o,
  output logic [15:0] exc_count_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DRAIN    = 2'd1;
  localparam logic [1:0] COMMIT   = 2'd2;
  localparam logic [1:0] REDIRECT = 2'd3;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
  localparam logic [4:0]  CODE_ERET  = 5'he;

  logic [1:0]  state;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        ds_q;
  logic [31:0] bad_q;
  logic [15:0] count_q;

  logic        ip;
  logic        det_valid;
  logic [4:0]  det_code;
  logic        bad_from_pc;
  logic        bad_from_mem;
  logic        enter_commit;
  logic        commit_counts;

  assign ip = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));

  // Priority chain also records which address source the winner uses, since
  // adel_if and adel share code 0x4 but latch different addresses.
  always_comb begin
    det_code     = '0;
    bad_from_pc  = 1'b0;
    bad_from_mem = 1'b0;
    if (ip)             det_code = 5'h1;
    else if (adel_if_i) begin det_code = 5'h4; bad_from_pc = 1'b1; end
    else if (ri_i)      det_code = 5'ha;
    else if (ov_i)      det_code = 5'hc;
    else if (trap_i)    det_code = 5'hd;
    else if (syscall_i) det_code = 5'h8;
    else if (break_i)   det_code = 5'h9;
    else if (adel_i)    begin det_code = 5'h4; bad_from_mem = 1'b1; end
    else if (ades_i)    begin det_code = 5'h5; bad_from_mem = 1'b1; end
    else if (eret_i)    det_code = CODE_ERET;
  end

  assign det_valid = (state == IDLE) & valid_i &
                     (ip | adel_if_i | ri_i | ov_i | trap_i | syscall_i |
                      break_i | adel_i | ades_i | eret_i);

  always_comb begin
    enter_commit  = 1'b0;
    commit_counts = 1'b0;
    if (det_valid && !mem_busy_i) begin
      enter_commit  = 1'b1;
      commit_counts = (det_code != CODE_ERET);
    end else if (state == DRAIN && !mem_busy_i) begin
      enter_commit  = 1'b1;
      commit_counts = (code_q != CODE_ERET);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      code_q  <= '0;
      pc_q    <= '0;
      ds_q    <= 1'b0;
      bad_q   <= '0;
      count_q <= '0;
    end else begin
      if (enter_commit && commit_counts) count_q <= count_q + 16'd1;
      case (state)
        IDLE: begin
          if (det_valid) begin
            code_q <= det_code;
            pc_q   <= pc_i;
            ds_q   <= in_delayslot_i;
            if (bad_from_pc)       bad_q <= pc_i;
            else if (bad_from_mem) bad_q <= mem_addr_i;
            state <= mem_busy_i ? DRAIN : COMMIT;
          end
        end
        DRAIN:    if (!mem_busy_i) state <= COMMIT;
        COMMIT:   state <= REDIRECT;
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign excepttype_o    = (state == COMMIT) ? {27'd0, code_q} : '0;
  assign exc_pc_o        = pc_q;
  assign exc_delayslot_o = ds_q;
  assign bad_addr_o      = bad_q;
  assign stall_o         = (state == DRAIN);
  assign flush_o         = (state == COMMIT) || (state == REDIRECT);
  assign redirect_o      = (state == REDIRECT);
  assign newpc_o         = (state == REDIRECT && code_q == CODE_ERET) ? epc_i : EXC_VECTOR;
  assign exc_count_o     = count_q;

endmodule
